shift_rows_engine: RTL and testbench
====================================

Name: shift_rows_engine

Overview:
- Registered, parametrised ShiftRows/InvShiftRows unit for the Rijndael round datapath.
- Supports block widths NB = 4..8 columns, with the Rijndael row offsets selected per NB.
- Direction (forward or inverse) is selected per transaction.
- Input and output use valid/ready handshakes, with a 2-entry output buffer so the block can sit between round stages without bubbles.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4..8; any other value is a elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each state; legal values 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inValid  input  1  input state present.
- inReady  output  1  block can accept the input this cycle.
- inverse  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the accepted input.
- inTag  input  TAG_W  sideband tag; sampled with the accepted input.
- currentState  input  32*NB  input state.
- flush  input  1  synchronous clear of buffered entries.
- outValid  output  1  output entry present.
- outReady  input  1  downstream accepts the output.
- newState  output  32*NB  shifted state.
- outTag  output  TAG_W  tag of the output entry.
- outInverse  output  1  direction used for the output entry.
- xferCount  output  16  number of output handshakes completed.

Behaviour:
- State layout:
  - Column c (0 = leftmost) occupies bits [32*NB-1-32c -: 32].
  - Row r of column c is byte [32*NB-1-32c-8r -: 8].
  - Row 0 of each column is in the MSB byte of that column.
- Row offsets (o0, o1, o2, o3):
  - NB 4..6: (0, 1, 2, 3).
  - NB 7: (0, 1, 2, 4).
  - NB 8: (0, 1, 3, 4).
  - Offsets are fixed at elaboration.
- Forward mode: out[r][c] = in[r][(c+o_r) mod NB].
- Inverse mode: out[r][(c+o_r) mod NB] = in[r][c].
- All column indices wrap mod NB.
- Row 0 always passes unchanged.
- Input acceptance:
  - The input is accepted on a rising edge when inValid && inReady.
  - The shift is computed combinationally from currentState and inverse.
  - The result, inTag and inverse are written into the buffer on the same edge.
- Latency: an accepted input appears on the outputs on the next cycle (1 cycle) when the buffer was empty.
- Buffer: 2-entry FIFO with registered outputs.
  - inReady = (entries < 2). It is derived from registered state only, with no combinational path from outReady.
  - Simultaneous push and pop with 1 entry: the count stays 1; the new entry becomes the head on the next cycle.
  - Simultaneous push and pop with 2 entries is impossible, because inReady = 0.
  - Pop with 0 entries is impossible, because outValid = 0.
  - When full, the upstream data is held by the upstream side. The block must not sample currentState while inReady = 0.
- Output:
  - outValid = (entries > 0).
  - newState, outTag and outInverse reflect the head entry.
  - These outputs are stable while outValid && !outReady.
- xferCount:
  - Increments on each cycle with outValid && outReady.
  - Wraps from 16'hFFFF to 0.
  - Is not cleared by flush.
- flush:
  - On the edge it is sampled high, the entry count goes to 0.
  - Any push in that same cycle is discarded.
  - A pop in that same cycle still counts in xferCount.
  - inReady = 1 on the following cycle.
- Reset (rst_n low, asynchronous):
  - Entries = 0, outValid = 0, xferCount = 0.
  - newState = 0, outTag = 0, outInverse = 0.
  - inReady reads 0 while rst_n is low and 1 from the first clock after release.
- Reset mid-transfer: buffered entries are lost. No output handshake is generated for them.

Test Plan:
- NB=4, forward: input d42711aee0bf98f1b8b45de51e415230 with tag 3 -> one cycle later outValid=1, newState = d4bf5d30e0b452aeb84111f11e2798e5, outTag=3, outInverse=0.
- NB=4, inverse: input d4bf5d30e0b452aeb84111f11e2798e5 -> newState = d42711aee0bf98f1b8b45de51e415230; a forward then inverse round trip on 1000 random states returns the original each time.
- NB=8: input bytes 00..1f in column-major order, forward -> row1 = 05,09,...,01 (offset 1), row2 shifted by 3, row3 shifted by 4; the inverse restores the input. Repeat the check for NB=6 and NB=7.
- Backpressure: hold outReady=0 and offer 3 inputs -> 2 accepted, inReady=0 with the 3rd held; raise outReady -> outputs appear in order with correct tags; xferCount=3 after drain.
- Streaming: inValid=1 and outReady=1 for 100 cycles -> 100 outputs on consecutive cycles with no bubbles; xferCount=100.
- Flush and reset: with 2 entries buffered, pulse flush -> outValid=0 next cycle and xferCount unchanged; with 1 entry buffered, assert rst_n=0 asynchronously mid-cycle -> outValid=0 and xferCount=0 immediately.

Source files
------------

// File: rtl/shift_rows_engine.sv
// Registered ShiftRows / InvShiftRows stage for NB = 4..8 column Rijndael states,
// with valid/ready handshakes and a 2-entry output buffer for bubble-free streaming.
module shift_rows_engine #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inverse,
    input  logic [TAG_W-1:0]  inTag,
    input  logic [32*NB-1:0]  currentState,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [32*NB-1:0]  newState,
    output logic [TAG_W-1:0]  outTag,
    output logic              outInverse,
    output logic [15:0]       xferCount
);

    // state  | meaning
    // EMPTY  | no buffered entries, outputs idle
    // ONE    | head entry valid, tail free
    // FULL   | head and tail valid, upstream stalled

    localparam int W    = 32 * NB;
    localparam int OFF2 = (NB == 8) ? 3 : 2;
    localparam int OFF3 = (NB >= 7) ? 4 : 3;

    generate
        if (NB < 4 || NB > 8) begin : gBadNb
            $error("shift_rows_engine: NB must be in 4..8");
        end
        if (TAG_W < 1 || TAG_W > 16) begin : gBadTag
            $error("shift_rows_engine: TAG_W must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fillState_t;

    fillState_t state;
    fillState_t nextState;

    logic [W-1:0]     fwdState;
    logic [W-1:0]     invState;
    logic [W-1:0]     shifted;

    logic [W-1:0]     headState;
    logic [TAG_W-1:0] headTag;
    logic             headInv;
    logic [W-1:0]     tailState;
    logic [TAG_W-1:0] tailTag;
    logic             tailInv;

    logic             rdyArm;
    logic             push;
    logic             pop;
    logic             loadHeadIn;
    logic             loadHeadTail;
    logic             loadTail;

    // Both permutations are pure wiring; only the final select costs logic.
    generate
        for (genvar r = 0; r < 4; r++) begin : gRow
            localparam int OFF = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? OFF2 : OFF3;
            for (genvar c = 0; c < NB; c++) begin : gCol
                localparam int FSRC = (c + OFF) % NB;
                localparam int ISRC = (c + NB - OFF) % NB;
                assign fwdState[W-1-32*c-8*r -: 8] = currentState[W-1-32*FSRC-8*r -: 8];
                assign invState[W-1-32*c-8*r -: 8] = currentState[W-1-32*ISRC-8*r -: 8];
            end
        end
    endgenerate

    assign shifted = inverse ? invState : fwdState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            rdyArm <= 1'b0;
        end else begin
            state  <= nextState;
            rdyArm <= 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) nextState = ONE;
                ONE: begin
                    if (push && !pop) nextState = FULL;
                    else if (!push && pop) nextState = EMPTY;
                end
                FULL:  if (pop) nextState = ONE;
                default: nextState = EMPTY;
            endcase
        end
    end

    // inReady depends only on flops, so outReady never reaches it combinationally.
    always_comb begin
        inReady      = rdyArm && (state != FULL);
        outValid     = (state != EMPTY);
        push         = inValid && inReady && !flush;
        pop          = outValid && outReady;
        loadHeadIn   = push && ((state == EMPTY) || ((state == ONE) && pop));
        loadTail     = push && (state == ONE) && !pop;
        loadHeadTail = pop && (state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headState <= '0;
            headTag   <= '0;
            headInv   <= 1'b0;
            tailState <= '0;
            tailTag   <= '0;
            tailInv   <= 1'b0;
        end else begin
            if (loadHeadIn) begin
                headState <= shifted;
                headTag   <= inTag;
                headInv   <= inverse;
            end else if (loadHeadTail) begin
                headState <= tailState;
                headTag   <= tailTag;
                headInv   <= tailInv;
            end
            if (loadTail) begin
                tailState <= shifted;
                tailTag   <= inTag;
                tailInv   <= inverse;
            end
        end
    end

    // A pop coinciding with flush is still a completed handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xferCount <= 16'd0;
        end else if (pop) begin
            xferCount <= xferCount + 16'd1;
        end
    end

    assign newState   = headState;
    assign outTag     = headTag;
    assign outInverse = headInv;

endmodule

// File: tb/tb_shift_rows_engine.sv
// Scoreboard bench for shift_rows_engine: NB=4 main instance plus NB=6/7/8 instances
// checked against a scatter-style reference permutation.
module tb_shift_rows_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid, inReady, inverse, flush, outValid, outReady, outInverse;
    logic [3:0]   inTag, outTag;
    logic [127:0] currentState, newState;
    logic [15:0]  xferCount;

    logic [2:0]       xValid, xInv, xRdy, xOv, xOinv;
    logic [2:0][3:0]  xOtag;
    logic [2:0][15:0] xXfer;
    logic [191:0]     cs6, ns6;
    logic [223:0]     cs7, ns7;
    logic [255:0]     cs8, ns8;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   tag;
        logic         inv;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_rows_engine #(.NB(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .inverse(inverse), .inTag(inTag), .currentState(currentState), .flush(flush),
        .outValid(outValid), .outReady(outReady), .newState(newState),
        .outTag(outTag), .outInverse(outInverse), .xferCount(xferCount)
    );

    shift_rows_engine #(.NB(6), .TAG_W(4)) u6 (
        .clk(clk), .rst_n(rst_n), .inValid(xValid[0]), .inReady(xRdy[0]),
        .inverse(xInv[0]), .inTag(4'd1), .currentState(cs6), .flush(1'b0),
        .outValid(xOv[0]), .outReady(1'b1), .newState(ns6),
        .outTag(xOtag[0]), .outInverse(xOinv[0]), .xferCount(xXfer[0])
    );

    shift_rows_engine #(.NB(7), .TAG_W(4)) u7 (
        .clk(clk), .rst_n(rst_n), .inValid(xValid[1]), .inReady(xRdy[1]),
        .inverse(xInv[1]), .inTag(4'd2), .currentState(cs7), .flush(1'b0),
        .outValid(xOv[1]), .outReady(1'b1), .newState(ns7),
        .outTag(xOtag[1]), .outInverse(xOinv[1]), .xferCount(xXfer[1])
    );

    shift_rows_engine #(.NB(8), .TAG_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .inValid(xValid[2]), .inReady(xRdy[2]),
        .inverse(xInv[2]), .inTag(4'd3), .currentState(cs8), .flush(1'b0),
        .outValid(xOv[2]), .outReady(1'b1), .newState(ns8),
        .outTag(xOtag[2]), .outInverse(xOinv[2]), .xferCount(xXfer[2])
    );

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference written as a scatter for the inverse so it is not the same gather as the design.
    function automatic logic [255:0] refShift(input int nb, input logic [255:0] s, input logic inv);
        int off [4];
        int dc;
        logic [255:0] r;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb >= 7) ? 4 : 3;
        r = '0;
        for (int c = 0; c < nb; c++) begin
            for (int row = 0; row < 4; row++) begin
                dc = (c + off[row]) % nb;
                if (!inv) r[32*nb-8-32*c-8*row +: 8] = s[32*nb-8-32*dc-8*row +: 8];
                else      r[32*nb-8-32*dc-8*row +: 8] = s[32*nb-8-32*c-8*row +: 8];
            end
        end
        return r;
    endfunction

    // Called at a falling edge; drives one cycle and scores the handshakes of the next rising edge.
    task automatic step(input logic v, input logic [127:0] d, input logic inv,
                        input logic [3:0] tg, input logic ordy, input logic fl);
        exp_t e;
        logic [255:0] m;
        inValid = v; currentState = d; inverse = inv; inTag = tg; outReady = ordy; flush = fl;
        #1;
        if (outValid && outReady) begin
            checkVal("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkVal("out_state", newState, e.st);
                checkVal("out_tag", outTag, e.tag);
                checkVal("out_inv", outInverse, e.inv);
            end
        end
        if (fl) begin
            sb.delete();
        end else if (inValid && inReady) begin
            m = refShift(4, {128'd0, d}, inv);
            e.st = m[127:0]; e.tag = tg; e.inv = inv;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic setCs(input int k, input logic [255:0] s);
        case (k)
            0: cs6 = s[191:0];
            1: cs7 = s[223:0];
            default: cs8 = s;
        endcase
    endtask

    function automatic logic [255:0] getNs(input int k);
        case (k)
            0: return {64'd0, ns6};
            1: return {32'd0, ns7};
            default: return ns8;
        endcase
    endfunction

    task automatic nbCheck(input int k, input int nb);
        logic [255:0] s, f;
        logic [63:0]  rw1, rw2, rw3;
        logic [7:0]   b8;
        s = '0;
        for (int b = 0; b < 4*nb; b++) begin
            b8 = b[7:0];
            s[8*(4*nb-1-b) +: 8] = b8;
        end
        checkVal("nb_rdy", xRdy[k], 1'b1);
        setCs(k, s); xInv[k] = 1'b0; xValid[k] = 1'b1;
        @(negedge clk);
        checkVal("nb_fwd_valid", xOv[k], 1'b1);
        f = refShift(nb, s, 1'b0);
        checkVal("nb_fwd", getNs(k), f);
        checkVal("nb_fwd_tag", xOtag[k], 4'(k + 1));
        if (nb == 8) begin
            for (int c = 0; c < 8; c++) begin
                rw1[63-8*c -: 8] = ns8[255-32*c-8 -: 8];
                rw2[63-8*c -: 8] = ns8[255-32*c-16 -: 8];
                rw3[63-8*c -: 8] = ns8[255-32*c-24 -: 8];
            end
            checkVal("nb8_row1", rw1, 64'h05090d1115191d01);
            checkVal("nb8_row2", rw2, 64'h0e12161a1e02060a);
            checkVal("nb8_row3", rw3, 64'h13171b1f03070b0f);
        end
        setCs(k, getNs(k)); xInv[k] = 1'b1;
        @(negedge clk);
        xValid[k] = 1'b0;
        checkVal("nb_inv", getNs(k), s);
        checkVal("nb_inv_dir", xOinv[k], 1'b1);
        @(negedge clk);
        checkVal("nb_xfer", xXfer[k], 16'd2);
        checkVal("nb_drained", xOv[k], 1'b0);
    endtask

    initial begin
        logic [127:0] a, b, c, s, fwd;
        logic [255:0] m;
        logic [15:0]  base, diff;

        rst_n = 1'b0;
        inValid = 0; inverse = 0; inTag = '0; currentState = '0; flush = 0; outReady = 0;
        xValid = '0; xInv = '0; cs6 = '0; cs7 = '0; cs8 = '0;
        repeat (2) @(negedge clk);
        checkVal("rst_outValid", outValid, 1'b0);
        checkVal("rst_inReady", inReady, 1'b0);
        checkVal("rst_xfer", xferCount, 16'd0);
        checkVal("rst_state", newState, 128'd0);
        checkVal("rst_tag", outTag, 4'd0);
        checkVal("rst_inv", outInverse, 1'b0);
        rst_n = 1'b1;
        #1 checkVal("rel_inReady_low", inReady, 1'b0);
        @(negedge clk);
        checkVal("rel_inReady_high", inReady, 1'b1);

        step(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd3, 1'b1, 1'b0);
        checkVal("vec_fwd_valid", outValid, 1'b1);
        checkVal("vec_fwd", newState, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        checkVal("vec_fwd_tag", outTag, 4'd3);
        checkVal("vec_fwd_dir", outInverse, 1'b0);
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b0);

        step(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'd5, 1'b1, 1'b0);
        checkVal("vec_inv", newState, 128'hd42711aee0bf98f1b8b45de51e415230);
        checkVal("vec_inv_dir", outInverse, 1'b1);
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, s, 1'b0, 4'(i), 1'b1, 1'b0);
            fwd = newState;
            step(1'b1, fwd, 1'b1, 4'(i + 1), 1'b1, 1'b0);
            checkVal("round_trip", newState, s);
        end
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b0);

        base = xferCount;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, a, 1'b0, 4'd1, 1'b0, 1'b0);
        step(1'b1, b, 1'b1, 4'd2, 1'b0, 1'b0);
        checkVal("bp_full_rdy", inReady, 1'b0);
        checkVal("bp_full_valid", outValid, 1'b1);
        step(1'b1, c, 1'b0, 4'd3, 1'b0, 1'b0);
        m = refShift(4, {128'd0, a}, 1'b0);
        checkVal("bp_held_rdy", inReady, 1'b0);
        checkVal("bp_head_stable", newState, m[127:0]);
        step(1'b1, c, 1'b0, 4'd3, 1'b1, 1'b0);
        step(1'b1, c, 1'b0, 4'd3, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b0);
        diff = xferCount - base;
        checkVal("bp_xfer", diff, 16'd3);
        checkVal("bp_drained", outValid, 1'b0);

        base = xferCount;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) checkVal("stream_valid", outValid, 1'b1);
            checkVal("stream_rdy", inReady, 1'b1);
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'(i), 4'(i), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b0);
        diff = xferCount - base;
        checkVal("stream_xfer", diff, 16'd100);

        step(1'b1, a, 1'b0, 4'd7, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 4'd8, 1'b0, 1'b0);
        base = xferCount;
        step(1'b1, c, 1'b0, 4'd9, 1'b0, 1'b1);
        checkVal("flush_valid", outValid, 1'b0);
        checkVal("flush_xfer", xferCount, base);
        checkVal("flush_rdy", inReady, 1'b1);
        step(1'b1, a, 1'b1, 4'd4, 1'b0, 1'b0);
        base = xferCount;
        step(1'b0, '0, 1'b0, 4'd0, 1'b1, 1'b1);
        diff = xferCount - base;
        checkVal("flush_pop_xfer", diff, 16'd1);
        checkVal("flush_pop_valid", outValid, 1'b0);
        inValid = 1'b0; flush = 1'b0; outReady = 1'b0;

        nbCheck(0, 6);
        nbCheck(1, 7);
        nbCheck(2, 8);

        step(1'b1, a, 1'b0, 4'd6, 1'b0, 1'b0);
        checkVal("ar_pre_valid", outValid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("ar_valid", outValid, 1'b0);
        checkVal("ar_xfer", xferCount, 16'd0);
        checkVal("ar_state", newState, 128'd0);
        checkVal("ar_rdy", inReady, 1'b0);
        sb.delete();
        inValid = 1'b0; outReady = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("ar_rel_rdy", inReady, 1'b1);
        checkVal("ar_rel_valid", outValid, 1'b0);
        checkVal("ar_rel_xfer", xferCount, 16'd0);
        checkVal("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
